exception_ctrl: RTL and testbench
=================================

// Module: exception_ctrl
// PURPOSE
//  Precise-exception controller at the memory/commit stage of the pipeline.
//  - Prioritises exception requests, with a parametrised interrupt vector.
//  - Computes the redirect PC, EPC, BadVAddr and ExcCode, and pulses the CP0 write.
//  - Drives a flush handshake: flush is held until the fetch unit acknowledges the restart.
//  - Adds over the previous generation: N interrupt lines, vectored interrupts, an explicit FSM and N flush fan-outs.
// PARAMETERS
//  NUM_INT      8              number of interrupt lines (1..32)
//  FLUSH_PORTS  3              number of auxiliary flush outputs (vice_flush)
//  VEC_SPACING  32'h20         byte stride between interrupt vectors (vectored mode)
//  BEV_BASE     32'hBFC00200   exception base when sr_bev=1
// PORTS
//  clk          in   1            clock
//  reset        in   1            synchronous, active-high reset
//  req          in   exc_req_t    packed exception requests: illegal_inst, inst_miss, inst_invalid,
//                                 unknown_inst, overflow, syscall, brk, trap, illegal_data,
//                                 data_miss, data_invalid, data_mod, eret
//  data_we      in   1            faulting data access is a store
//  pc           in   32           fetch PC of the faulting instruction
//  data_vaddr   in   32           faulting data virtual address
//  cur_epc      in   32           EPC candidate (PC, or PC-4 if in a delay slot)
//  cp0_epc      in   32           current CP0.EPC (eret target; nested refill)
//  ebase        in   32           CP0.EBase
//  int_pending  in   NUM_INT      Cause.IP & Status.IM, per line
//  allow_int    in   1            IE & !EXL & !ERL
//  sr_bev       in   1            Status.BEV
//  sr_exl       in   1            Status.EXL
//  cause_iv     in   1            Cause.IV
//  fetch_ok     in   1            fetch unit has restarted at new_pc
//  exc_any      out  1            combinational: any request accepted this cycle
//  flush        out  1            main pipeline flush
//  vice_flush   out  FLUSH_PORTS  replicated flush for auxiliary units
//  cp0_wr_exp   out  1            one-cycle pulse: CP0 latches exc_code/epc/badvaddr
//  clear_exl    out  1            one-cycle pulse on eret
//  exc_code     out  5            ExcCode (codes from exc_pkg)
//  epc_out      out  32           EPC to write
//  badvaddr     out  32           BadVAddr to write
//  badvaddr_we  out  1            BadVAddr write enable (pulse)
//  new_pc       out  32           redirect target; valid while flush=1
//  busy         out  1            FSM state is not IDLE
// BEHAVIOUR
//  Reset values: all outputs 0; FSM in IDLE.
//  base = sr_bev ? BEV_BASE : ebase.
//  FSM states:
//   - IDLE: if exc_any, register the outputs and go to REDIRECT.
//   - REDIRECT: lasts 1 cycle; cp0_wr_exp / clear_exl / badvaddr_we are high only here; go to DRAIN.
//   - DRAIN: flush and vice_flush are held; on fetch_ok go to IDLE, and flush drops the next cycle.
//  Latency: request sampled in cycle N; outputs are valid in N+1; flush is low at the earliest in N+3.
//  fetch_ok sampled during REDIRECT is ignored.
//  Requests arriving in REDIRECT or DRAIN are dropped (the pipeline is squashed), and exc_any is
//  forced to 0 in those states.
//  Priority (highest first): interrupt (allow_int & |int_pending), illegal_inst, inst_miss,
//  inst_invalid, unknown_inst, overflow, syscall, brk, trap, illegal_data, data_miss,
//  data_invalid, data_mod (counts only when data_we=1), eret.
//  Vectors:
//   - refill (inst_miss/data_miss): base+0 when sr_exl=0, else base+0x180 with epc_out=cp0_epc.
//   - interrupt: see CONFIGURATION.
//   - all others: base+0x180.
//   - eret: new_pc=cp0_epc, cp0_wr_exp=0, clear_exl=1.
//  Store/load codes: data faults use data_we to select the code (ADES/ADEL, TLBS/TLBL).
//  BadVAddr source: pc for inst-side faults, data_vaddr for data-side faults; badvaddr_we=0 otherwise.
//  Arithmetic: all address math is 32-bit modulo 2^32 (wraps silently).
//  Reset asserted in any state returns to IDLE and clears every output in the same edge.
// CONFIGURATION
//  EXC_VEC_INT_EN defined:
//   - if cause_iv & !sr_bev: interrupt new_pc = base+0x200+idx*VEC_SPACING,
//     where idx = index of the highest set bit of int_pending.
//   - otherwise the undefined-macro rule applies.
//  EXC_VEC_INT_EN undefined: interrupt new_pc = cause_iv ? base+0x200 : base+0x180.
// STRUCTURE
//  exc_pkg: exc_req_t struct, EX_* ExcCode constants, state_e enum, vector offset constants.
//  Sub-module exc_prio_enc: combinational priority encoder from req/int_pending to a
//  {kind, exc_code, bad_sel, vec_sel} record; exception_ctrl holds the FSM and output registers.
// TESTING
//  1. syscall=1, cur_epc=0x80001000, sr_bev=0, ebase=0x80000000 -> in N+1: exc_code=8,
//     new_pc=0x80000180, epc_out=0x80001000, cp0_wr_exp pulses 1 cycle, badvaddr_we=0.
//  2. data_miss + data_we=1, data_vaddr=0x00400004, sr_exl=0 -> exc_code=3 (TLBS), new_pc=ebase,
//     badvaddr=0x00400004; repeat with sr_exl=1 -> new_pc=ebase+0x180, epc_out=cp0_epc.
//  3. overflow and int_pending=0x04 with allow_int=1 together -> interrupt wins, exc_code=0;
//     with allow_int=0 -> exc_code=12.
//  4. EXC_VEC_INT_EN defined, cause_iv=1, int_pending=0x24, VEC_SPACING=0x20 -> new_pc=ebase+0x2A0;
//     macro undefined -> ebase+0x200.
//  5. eret, cp0_epc=0xBFC00380 -> new_pc=0xBFC00380, clear_exl pulse, cp0_wr_exp=0;
//     fetch_ok held low 5 cycles -> flush stays high, and a syscall injected during DRAIN is dropped.
//  6. reset asserted in DRAIN -> next cycle flush=0, busy=0, all outputs 0.

Source files
------------

// File: rtl/exc_pkg.sv
// rtl/exc_pkg.sv - shared types, ExcCode constants and vector offsets for the exception controller
package exc_pkg;

   typedef struct packed {
      logic illegal_inst;
      logic inst_miss;
      logic inst_invalid;
      logic unknown_inst;
      logic overflow;
      logic syscall;
      logic brk;
      logic trap;
      logic illegal_data;
      logic data_miss;
      logic data_invalid;
      logic data_mod;
      logic eret;
   } exc_req_t;

   localparam logic [4:0] EX_INT  = 5'd0;
   localparam logic [4:0] EX_MOD  = 5'd1;
   localparam logic [4:0] EX_TLBL = 5'd2;
   localparam logic [4:0] EX_TLBS = 5'd3;
   localparam logic [4:0] EX_ADEL = 5'd4;
   localparam logic [4:0] EX_ADES = 5'd5;
   localparam logic [4:0] EX_SYS  = 5'd8;
   localparam logic [4:0] EX_BP   = 5'd9;
   localparam logic [4:0] EX_RI   = 5'd10;
   localparam logic [4:0] EX_OV   = 5'd12;
   localparam logic [4:0] EX_TR   = 5'd13;

   localparam logic [31:0] OFF_REFILL  = 32'h0000_0000;
   localparam logic [31:0] OFF_GENERAL = 32'h0000_0180;
   localparam logic [31:0] OFF_INT     = 32'h0000_0200;

   typedef enum logic [1:0] {S_IDLE, S_REDIRECT, S_DRAIN} state_e;
   typedef enum logic [1:0] {K_NONE, K_EXC, K_ERET} kind_e;
   typedef enum logic [1:0] {BAD_NONE, BAD_PC, BAD_DATA} bad_sel_e;
   typedef enum logic [1:0] {VEC_GENERAL, VEC_REFILL, VEC_INT, VEC_ERET} vec_sel_e;

   typedef struct packed {
      kind_e      kind;
      logic [4:0] exc_code;
      bad_sel_e   bad_sel;
      vec_sel_e   vec_sel;
   } exc_rec_t;

   function automatic logic [4:0] highest_set(input logic [31:0] v);
      logic [4:0] idx;
      idx = 5'd0;
      for (int i = 0; i < 32; i++) begin
         if (v[i]) idx = 5'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/exc_prio_enc.sv
// rtl/exc_prio_enc.sv - fixed-priority encoder from exception requests to a cause record
module exc_prio_enc
   import exc_pkg::*;
#(
   parameter int NUM_INT = 8
) (
   input  exc_req_t             req,
   input  logic [NUM_INT-1:0]   int_pending,
   input  logic                 allow_int,
   input  logic                 data_we,
   output exc_rec_t             rec
);

   always_comb begin
      rec.kind     = K_EXC;
      rec.exc_code = EX_INT;
      rec.bad_sel  = BAD_NONE;
      rec.vec_sel  = VEC_GENERAL;
      if (allow_int && (|int_pending)) begin
         rec.vec_sel = VEC_INT;
      end else if (req.illegal_inst) begin
         rec.exc_code = EX_ADEL;
         rec.bad_sel  = BAD_PC;
      end else if (req.inst_miss) begin
         rec.exc_code = EX_TLBL;
         rec.bad_sel  = BAD_PC;
         rec.vec_sel  = VEC_REFILL;
      end else if (req.inst_invalid) begin
         rec.exc_code = EX_TLBL;
         rec.bad_sel  = BAD_PC;
      end else if (req.unknown_inst) begin
         rec.exc_code = EX_RI;
      end else if (req.overflow) begin
         rec.exc_code = EX_OV;
      end else if (req.syscall) begin
         rec.exc_code = EX_SYS;
      end else if (req.brk) begin
         rec.exc_code = EX_BP;
      end else if (req.trap) begin
         rec.exc_code = EX_TR;
      end else if (req.illegal_data) begin
         rec.exc_code = data_we ? EX_ADES : EX_ADEL;
         rec.bad_sel  = BAD_DATA;
      end else if (req.data_miss) begin
         rec.exc_code = data_we ? EX_TLBS : EX_TLBL;
         rec.bad_sel  = BAD_DATA;
         rec.vec_sel  = VEC_REFILL;
      end else if (req.data_invalid) begin
         rec.exc_code = data_we ? EX_TLBS : EX_TLBL;
         rec.bad_sel  = BAD_DATA;
      end else if (req.data_mod && data_we) begin
         // a modify fault is only meaningful for a store
         rec.exc_code = EX_MOD;
         rec.bad_sel  = BAD_DATA;
      end else if (req.eret) begin
         rec.kind    = K_ERET;
         rec.vec_sel = VEC_ERET;
      end else begin
         rec.kind = K_NONE;
      end
   end

endmodule

// File: rtl/exception_ctrl.sv
// rtl/exception_ctrl.sv - precise-exception FSM and redirect/flush control; EXC_VEC_INT_EN enables vectored interrupts
module exception_ctrl
   import exc_pkg::*;
#(
   parameter int          NUM_INT     = 8,
   parameter int          FLUSH_PORTS = 3,
   parameter logic [31:0] VEC_SPACING = 32'h20,
   parameter logic [31:0] BEV_BASE    = 32'hBFC0_0200
) (
   input  logic                   clk,
   input  logic                   reset,
   input  exc_req_t               req,
   input  logic                   data_we,
   input  logic [31:0]            pc,
   input  logic [31:0]            data_vaddr,
   input  logic [31:0]            cur_epc,
   input  logic [31:0]            cp0_epc,
   input  logic [31:0]            ebase,
   input  logic [NUM_INT-1:0]     int_pending,
   input  logic                   allow_int,
   input  logic                   sr_bev,
   input  logic                   sr_exl,
   input  logic                   cause_iv,
   input  logic                   fetch_ok,
   output logic                   exc_any,
   output logic                   flush,
   output logic [FLUSH_PORTS-1:0] vice_flush,
   output logic                   cp0_wr_exp,
   output logic                   clear_exl,
   output logic [4:0]             exc_code,
   output logic [31:0]            epc_out,
   output logic [31:0]            badvaddr,
   output logic                   badvaddr_we,
   output logic [31:0]            new_pc,
   output logic                   busy
);

   state_e      state;
   exc_rec_t    rec;
   logic [31:0] base;
   logic [31:0] target;
   logic [31:0] epc_next;

   exc_prio_enc #(.NUM_INT(NUM_INT)) u_prio (
      .req         (req),
      .int_pending (int_pending),
      .allow_int   (allow_int),
      .data_we     (data_we),
      .rec         (rec)
   );

   assign base    = sr_bev ? BEV_BASE : ebase;
   assign exc_any = (state == S_IDLE) && (rec.kind != K_NONE);
   assign busy    = (state != S_IDLE);

`ifdef EXC_VEC_INT_EN
   logic [31:0] int_vec_off;
   assign int_vec_off = {27'd0, highest_set(32'(int_pending))} * VEC_SPACING;
`endif

   always_comb begin
      target   = base + OFF_GENERAL;
      epc_next = cur_epc;
      case (rec.vec_sel)
         VEC_REFILL: begin
            // nested refill under EXL keeps the original EPC
            if (!sr_exl) target = base + OFF_REFILL;
            else         epc_next = cp0_epc;
         end
         VEC_INT: begin
`ifdef EXC_VEC_INT_EN
            if (cause_iv && !sr_bev) target = base + OFF_INT + int_vec_off;
            else
`endif
            if (cause_iv) target = base + OFF_INT;
         end
         VEC_ERET: target = cp0_epc;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= S_IDLE;
         flush       <= 1'b0;
         vice_flush  <= '0;
         cp0_wr_exp  <= 1'b0;
         clear_exl   <= 1'b0;
         exc_code    <= 5'd0;
         epc_out     <= 32'd0;
         badvaddr    <= 32'd0;
         badvaddr_we <= 1'b0;
         new_pc      <= 32'd0;
      end else begin
         cp0_wr_exp  <= 1'b0;
         clear_exl   <= 1'b0;
         badvaddr_we <= 1'b0;
         case (state)
            S_IDLE: begin
               if (exc_any) begin
                  state       <= S_REDIRECT;
                  flush       <= 1'b1;
                  vice_flush  <= '1;
                  exc_code    <= rec.exc_code;
                  epc_out     <= epc_next;
                  new_pc      <= target;
                  cp0_wr_exp  <= (rec.kind == K_EXC);
                  clear_exl   <= (rec.kind == K_ERET);
                  badvaddr_we <= (rec.bad_sel != BAD_NONE);
                  if (rec.bad_sel == BAD_PC)        badvaddr <= pc;
                  else if (rec.bad_sel == BAD_DATA) badvaddr <= data_vaddr;
               end
            end
            S_REDIRECT: state <= S_DRAIN;
            S_DRAIN: begin
               if (fetch_ok) begin
                  state      <= S_IDLE;
                  flush      <= 1'b0;
                  vice_flush <= '0;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_exception_ctrl.sv
// tb/tb_exception_ctrl.sv - table-driven scoreboard bench for exception_ctrl
module tb_exception_ctrl;
   import exc_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   exc_req_t    req;
   logic        data_we, allow_int, sr_bev, sr_exl, cause_iv, fetch_ok;
   logic [31:0] pc, data_vaddr, cur_epc, cp0_epc, ebase;
   logic [7:0]  int_pending;
   logic        exc_any, flush, cp0_wr_exp, clear_exl, badvaddr_we, busy;
   logic [2:0]  vice_flush;
   logic [4:0]  exc_code;
   logic [31:0] epc_out, badvaddr, new_pc;

   always #5 clk = ~clk;

   exception_ctrl dut (
      .clk(clk), .reset(reset), .req(req), .data_we(data_we), .pc(pc),
      .data_vaddr(data_vaddr), .cur_epc(cur_epc), .cp0_epc(cp0_epc), .ebase(ebase),
      .int_pending(int_pending), .allow_int(allow_int), .sr_bev(sr_bev), .sr_exl(sr_exl),
      .cause_iv(cause_iv), .fetch_ok(fetch_ok), .exc_any(exc_any), .flush(flush),
      .vice_flush(vice_flush), .cp0_wr_exp(cp0_wr_exp), .clear_exl(clear_exl),
      .exc_code(exc_code), .epc_out(epc_out), .badvaddr(badvaddr),
      .badvaddr_we(badvaddr_we), .new_pc(new_pc), .busy(busy)
   );

   typedef struct {
      string       name;
      exc_req_t    req;
      logic        data_we, allow_int, sr_bev, sr_exl, cause_iv;
      logic [31:0] pc, data_vaddr, cur_epc, cp0_epc, ebase;
      logic [7:0]  int_pending;
      logic [4:0]  code;
      logic [31:0] npc, epc, bad;
      logic        bad_we, wr, clr;
   } vec_t;

   int   n_checks = 0;
   int   n_fail = 0;
   vec_t tbl[$];
   vec_t sb[$];

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%b required=%b", name, act, exp);
      end
   endtask

   function automatic vec_t base_vec(input string name);
      vec_t v;
      v.name = name;       v.req = '0;           v.data_we = 1'b0;
      v.allow_int = 1'b0;  v.sr_bev = 1'b0;      v.sr_exl = 1'b0;     v.cause_iv = 1'b0;
      v.pc = 32'h8000_1000;  v.data_vaddr = 32'h0; v.cur_epc = 32'h8000_1000;
      v.cp0_epc = 32'h8000_2000; v.ebase = 32'h8000_0000; v.int_pending = 8'h00;
      v.code = 5'd0; v.npc = 32'h8000_0180; v.epc = 32'h8000_1000; v.bad = 32'h0;
      v.bad_we = 1'b0; v.wr = 1'b1; v.clr = 1'b0;
      return v;
   endfunction

   task automatic drive(input vec_t v);
      req = v.req; data_we = v.data_we; allow_int = v.allow_int; sr_bev = v.sr_bev;
      sr_exl = v.sr_exl; cause_iv = v.cause_iv; pc = v.pc; data_vaddr = v.data_vaddr;
      cur_epc = v.cur_epc; cp0_epc = v.cp0_epc; ebase = v.ebase; int_pending = v.int_pending;
   endtask

   task automatic clear_req();
      req = '0; int_pending = 8'h00; allow_int = 1'b0; data_we = 1'b0;
   endtask

   task automatic compare_redirect(input vec_t e);
      chk32({e.name, ".new_pc"}, new_pc, e.npc);
      chk1({e.name, ".cp0_wr_exp"}, cp0_wr_exp, e.wr);
      chk1({e.name, ".clear_exl"}, clear_exl, e.clr);
      chk1({e.name, ".badvaddr_we"}, badvaddr_we, e.bad_we);
      chk1({e.name, ".flush"}, flush, 1'b1);
      chk32({e.name, ".vice_flush"}, 32'(vice_flush), 32'h7);
      if (e.wr) begin
         chk32({e.name, ".exc_code"}, 32'(exc_code), 32'(e.code));
         chk32({e.name, ".epc_out"}, epc_out, e.epc);
      end
      if (e.bad_we) chk32({e.name, ".badvaddr"}, badvaddr, e.bad);
   endtask

   // caller is at a negedge with the DUT idle
   task automatic run_vec(input vec_t v);
      vec_t e;
      bit   got;
      drive(v);
      #1 chk1({v.name, ".exc_any"}, exc_any, 1'b1);
      sb.push_back(v);
      @(posedge clk);
      got = 1'b0;
      for (int k = 0; k < 4 && !got; k++) begin
         @(negedge clk);
         if (cp0_wr_exp || clear_exl) got = 1'b1;
      end
      e = sb.pop_front();
      if (!got) begin
         n_checks++; n_fail++;
         $display("FAIL %s.pulse_timeout: no cp0_wr_exp/clear_exl within 4 cycles", e.name);
      end else begin
         compare_redirect(e);
      end
      clear_req();
      fetch_ok = 1'b1;
      @(negedge clk);
      chk1({v.name, ".flush_drain"}, flush, 1'b1);
      chk1({v.name, ".pulse_width"}, cp0_wr_exp | clear_exl | badvaddr_we, 1'b0);
      @(negedge clk);
      chk1({v.name, ".flush_release"}, flush, 1'b0);
      chk1({v.name, ".busy_release"}, busy, 1'b0);
      fetch_ok = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t v;
      vec_t e;

      v = base_vec("syscall");  v.req.syscall = 1'b1; v.code = 5'd8; tbl.push_back(v);
      v = base_vec("dtlb_refill_st"); v.req.data_miss = 1'b1; v.data_we = 1'b1;
      v.data_vaddr = 32'h0040_0004; v.code = 5'd3; v.npc = 32'h8000_0000;
      v.bad = 32'h0040_0004; v.bad_we = 1'b1; tbl.push_back(v);
      v.name = "dtlb_refill_exl"; v.sr_exl = 1'b1; v.npc = 32'h8000_0180;
      v.epc = 32'h8000_2000; tbl.push_back(v);
      v = base_vec("int_beats_ov"); v.req.overflow = 1'b1; v.int_pending = 8'h04;
      v.allow_int = 1'b1; tbl.push_back(v);
      v.name = "ov_int_masked"; v.allow_int = 1'b0; v.code = 5'd12; tbl.push_back(v);
      v = base_vec("int_iv"); v.int_pending = 8'h24; v.allow_int = 1'b1; v.cause_iv = 1'b1;
`ifdef EXC_VEC_INT_EN
      v.npc = 32'h8000_02A0;
`else
      v.npc = 32'h8000_0200;
`endif
      tbl.push_back(v);
      v.name = "int_iv_bev"; v.sr_bev = 1'b1; v.npc = 32'hBFC0_0400; tbl.push_back(v);
      v = base_vec("eret"); v.req.eret = 1'b1; v.cp0_epc = 32'hBFC0_0380;
      v.npc = 32'hBFC0_0380; v.wr = 1'b0; v.clr = 1'b1; tbl.push_back(v);
      v = base_vec("adel_inst"); v.req.illegal_inst = 1'b1; v.req.syscall = 1'b1;
      v.code = 5'd4; v.bad = 32'h8000_1000; v.bad_we = 1'b1; tbl.push_back(v);
      v = base_vec("itlb_bev"); v.req.inst_miss = 1'b1; v.sr_bev = 1'b1; v.pc = 32'h0040_1000;
      v.code = 5'd2; v.npc = 32'hBFC0_0200; v.bad = 32'h0040_1000; v.bad_we = 1'b1; tbl.push_back(v);
      v = base_vec("ades"); v.req.illegal_data = 1'b1; v.data_we = 1'b1; v.data_vaddr = 32'h1003;
      v.code = 5'd5; v.bad = 32'h1003; v.bad_we = 1'b1; tbl.push_back(v);
      v.name = "adel_data"; v.data_we = 1'b0; v.code = 5'd4; tbl.push_back(v);
      v = base_vec("tlb_mod"); v.req.data_mod = 1'b1; v.data_we = 1'b1; v.data_vaddr = 32'h2000;
      v.code = 5'd1; v.bad = 32'h2000; v.bad_we = 1'b1; tbl.push_back(v);
      v = base_vec("tlbl_inv"); v.req.data_invalid = 1'b1; v.data_vaddr = 32'h3000;
      v.code = 5'd2; v.bad = 32'h3000; v.bad_we = 1'b1; tbl.push_back(v);
      v = base_vec("wrap"); v.req.syscall = 1'b1; v.ebase = 32'hFFFF_FF00;
      v.code = 5'd8; v.npc = 32'h0000_0080; tbl.push_back(v);
      v = base_vec("brk");  v.req.brk = 1'b1;          v.code = 5'd9;  tbl.push_back(v);
      v = base_vec("trap"); v.req.trap = 1'b1;         v.code = 5'd13; tbl.push_back(v);
      v = base_vec("ri");   v.req.unknown_inst = 1'b1; v.code = 5'd10; tbl.push_back(v);

      v = base_vec("idle"); drive(v); fetch_ok = 1'b0;
      repeat (2) @(negedge clk);
      chk1("reset.flush", flush, 1'b0);
      chk1("reset.busy", busy, 1'b0);
      chk32("reset.new_pc", new_pc, 32'h0);
      chk32("reset.exc_code", 32'(exc_code), 32'h0);
      chk1("reset.cp0_wr_exp", cp0_wr_exp, 1'b0);
      reset = 1'b0;
      @(negedge clk);

      foreach (tbl[i]) run_vec(tbl[i]);

      // store-only modify fault must not fire for a load
      v = base_vec("mod_load"); v.req.data_mod = 1'b1; drive(v);
      #1 chk1("mod_load.exc_any", exc_any, 1'b0);
      @(negedge clk);
      chk1("mod_load.busy", busy, 1'b0);
      clear_req();

      // eret with a slow fetch restart; a syscall during DRAIN is dropped
      v = base_vec("eret_hold"); v.req.eret = 1'b1; v.cp0_epc = 32'hBFC0_0380;
      v.npc = 32'hBFC0_0380; v.wr = 1'b0; v.clr = 1'b1;
      drive(v);
      #1 chk1("eret_hold.exc_any", exc_any, 1'b1);
      sb.push_back(v);
      @(negedge clk);
      e = sb.pop_front();
      compare_redirect(e);
      clear_req();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk1($sformatf("eret_hold.flush_%0d", i), flush, 1'b1);
         if (i == 1) begin
            req.syscall = 1'b1;
            #1 chk1("eret_hold.drain_exc_any", exc_any, 1'b0);
         end
         if (i == 3) req.syscall = 1'b0;
      end
      fetch_ok = 1'b1;
      @(negedge clk);
      chk1("eret_hold.flush_release", flush, 1'b0);
      fetch_ok = 1'b0;
      @(negedge clk);
      chk1("eret_hold.dropped_sys", cp0_wr_exp, 1'b0);
      chk1("eret_hold.idle", busy, 1'b0);

      // reset while draining
      v = base_vec("rst_drain"); v.req.syscall = 1'b1; drive(v);
      @(negedge clk);
      clear_req();
      @(negedge clk);
      chk1("rst_drain.pre_flush", flush, 1'b1);
      reset = 1'b1;
      @(negedge clk);
      chk1("rst_drain.flush", flush, 1'b0);
      chk1("rst_drain.busy", busy, 1'b0);
      chk32("rst_drain.vice_flush", 32'(vice_flush), 32'h0);
      chk32("rst_drain.new_pc", new_pc, 32'h0);
      chk32("rst_drain.epc_out", epc_out, 32'h0);
      chk32("rst_drain.exc_code", 32'(exc_code), 32'h0);
      reset = 1'b0;
      @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
